// File: rtl/manchester_receiver.sv
// Manchester line receiver: oversamples the line, recovers bit timing from mid-bit
// transitions, hunts preamble + sync word and delivers bytes through a one-beat output slot.
module manchester_receiver #(
  parameter int unsigned SPB          = 16,
  parameter int unsigned TOL          = 3,
  parameter int unsigned PREAMBLE_MIN = 8,
  parameter logic [7:0]  SYNC_WORD    = 8'hD5
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       serial_in,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       frame_active,
  output logic       eof,
  output logic       code_err,
  output logic       overrun
);

  localparam int unsigned CNT_MAX = SPB + TOL + 1;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned PW      = $clog2(PREAMBLE_MIN + 1);

  localparam logic [CW-1:0] MID_LO    = CW'(SPB - TOL);
  localparam logic [CW-1:0] MID_HI    = CW'(SPB + TOL);
  localparam logic [CW-1:0] BND_LO    = CW'(SPB / 2 - TOL);
  localparam logic [CW-1:0] BND_HI    = CW'(SPB / 2 + TOL);
  localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);
  localparam logic [PW-1:0] PMIN_LAST = PW'(PREAMBLE_MIN - 1);

  typedef enum logic [1:0] {HUNT, ACQUIRE, SYNC, DATA} state_t;

  state_t          state, state_n;
  logic            sync1, sync2, prev;
  logic [CW-1:0]   cnt, cnt_n;
  logic [PW-1:0]   pcnt, pcnt_n;
  logic [7:0]      sreg, sreg_n, sreg_shift;
  logic [7:0]      byte_sr, byte_n;
  logic [2:0]      bitcnt, bitcnt_n;
  logic            byte_done, byte_done_n;
  logic            eof_n, err_n;
  logic            line_edge, is_mid, is_bnd, timeout;

  always_ff @(posedge aclk) begin
    if (areset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= serial_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign line_edge = sync2 ^ prev;
  assign is_mid    = (cnt >= MID_LO) && (cnt <= MID_HI);
  assign is_bnd    = (cnt >= BND_LO) && (cnt <= BND_HI);
  assign timeout   = (cnt == CNT_SAT);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= HUNT;
      cnt       <= '0;
      pcnt      <= '0;
      sreg      <= '0;
      byte_sr   <= '0;
      bitcnt    <= '0;
      byte_done <= 1'b0;
      eof       <= 1'b0;
      code_err  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pcnt      <= pcnt_n;
      sreg      <= sreg_n;
      byte_sr   <= byte_n;
      bitcnt    <= bitcnt_n;
      byte_done <= byte_done_n;
      eof       <= eof_n;
      code_err  <= err_n;
    end
  end

  // Timeout is tested before edge classification so eof and code_err stay exclusive.
  always_comb begin
    state_n     = state;
    cnt_n       = timeout ? cnt : cnt + 1'b1;
    pcnt_n      = pcnt;
    sreg_n      = sreg;
    byte_n      = byte_sr;
    bitcnt_n    = bitcnt;
    byte_done_n = 1'b0;
    eof_n       = 1'b0;
    err_n       = 1'b0;
    sreg_shift  = {sreg[6:0], sync2};
    unique case (state)
      HUNT: begin
        cnt_n = '0;
        if (line_edge) begin
          state_n = ACQUIRE;
          pcnt_n  = '0;
        end
      end
      ACQUIRE: begin
        if (timeout) begin
          state_n = HUNT;
          cnt_n   = '0;
        end else if (line_edge) begin
          cnt_n = '0;
          if (is_mid) begin
            pcnt_n = pcnt + 1'b1;
            if (pcnt == PMIN_LAST) begin
              state_n = SYNC;
              sreg_n  = '0;
            end
          end else begin
            pcnt_n = '0;
          end
        end
      end
      SYNC: begin
        if (timeout) begin
          state_n = HUNT;
          cnt_n   = '0;
        end else if (line_edge) begin
          if (is_mid) begin
            cnt_n  = '0;
            sreg_n = sreg_shift;
            if (sreg_shift == SYNC_WORD) begin
              state_n  = DATA;
              bitcnt_n = '0;
            end
          end else if (!is_bnd) begin
            err_n   = 1'b1;
            state_n = HUNT;
            cnt_n   = '0;
          end
        end
      end
      DATA: begin
        if (timeout) begin
          eof_n   = 1'b1;
          state_n = HUNT;
          cnt_n   = '0;
        end else if (line_edge) begin
          if (is_mid) begin
            cnt_n  = '0;
            byte_n = {byte_sr[6:0], sync2};
            if (bitcnt == 3'd7) begin
              byte_done_n = 1'b1;
              bitcnt_n    = '0;
            end else begin
              bitcnt_n = bitcnt + 1'b1;
            end
          end else if (!is_bnd) begin
            err_n   = 1'b1;
            state_n = HUNT;
            cnt_n   = '0;
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

  assign frame_active = (state == SYNC) || (state == DATA);

  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      overrun       <= 1'b0;
    end else if (byte_done) begin
      if (!m_axis_tvalid || m_axis_tready) begin
        m_axis_tdata  <= byte_sr;
        m_axis_tvalid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_manchester_receiver.sv
// Directed bench for manchester_receiver: builds Manchester frames sample by sample
// and checks delivered beats, eof/code_err pulses, overrun and reset behaviour.
module tb_manchester_receiver;

  localparam int unsigned SPB = 16;
  localparam int unsigned TOL = 3;
  localparam int          EOF_DELAY = int'(SPB + TOL + 1) + 3;

  logic       aclk = 1'b0;
  logic       areset;
  logic       serial_in;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       frame_active;
  logic       eof;
  logic       code_err;
  logic       overrun;

  manchester_receiver #(
    .SPB(SPB),
    .TOL(TOL),
    .PREAMBLE_MIN(8),
    .SYNC_WORD(8'hD5)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .serial_in(serial_in),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .frame_active(frame_active),
    .eof(eof),
    .code_err(code_err),
    .overrun(overrun)
  );

  always #5 aclk = ~aclk;

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] rx_q[$];
  logic       tx_q[$];
  int         eof_cnt, err_cnt, both_cnt, eof_cyc, rise_cyc;
  int         lat_idx, lat_mark, last_mark;
  logic       tv_d;
  logic       jit_on;

  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    tv_d = 1'b0;
    forever begin
      @(negedge aclk);
      if (m_axis_tvalid && m_axis_tready) rx_q.push_back(m_axis_tdata);
      if (eof) begin
        eof_cnt = eof_cnt + 1;
        eof_cyc = cyc;
      end
      if (code_err) err_cnt = err_cnt + 1;
      if (eof && code_err) both_cnt = both_cnt + 1;
      if (m_axis_tvalid && !tv_d && rise_cyc < 0) rise_cyc = cyc;
      tv_d = m_axis_tvalid;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat(input int i);
    return (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic hold(input logic v, input int n);
    serial_in = v;
    repeat (n) @(negedge aclk);
  endtask

  // Mid-bit level change is sampled by the DUT on the following posedge (cyc + 1).
  task automatic send_bit(input logic b, input int idx);
    int h1, h2;
    h1 = int'(SPB / 2);
    h2 = int'(SPB / 2);
    if (jit_on) begin
      h1 = h1 + int'($urandom_range(2, 0)) - 1;
      h2 = h2 + int'($urandom_range(2, 0)) - 1;
    end
    hold(~b, h1);
    if (idx == lat_idx) lat_mark = cyc + 1;
    last_mark = cyc + 1;
    hold(b, h2);
  endtask

  task automatic send_q();
    for (int i = 0; i < tx_q.size(); i++) send_bit(tx_q[i], i);
    tx_q.delete();
  endtask

  task automatic q_pre(input int n);
    for (int i = 0; i < n; i++) tx_q.push_back((i % 2) == 0);
  endtask

  task automatic q_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) tx_q.push_back(b[i]);
  endtask

  task automatic q_frame();
    q_pre(16);
    q_bits(8'hD5, 8);
    q_bits(8'hA5, 8);
    q_bits(8'h3C, 8);
  endtask

  task automatic settle();
    hold(serial_in, 60);
    if (serial_in) hold(1'b0, 60);
  endtask

  task automatic set_ready(input logic v);
    @(posedge aclk);
    #1 m_axis_tready = v;
    @(negedge aclk);
  endtask

  task automatic clear();
    rx_q.delete();
    eof_cnt  = 0;
    err_cnt  = 0;
    both_cnt = 0;
    eof_cyc  = -1;
    rise_cyc = -1;
  endtask

  initial begin
    serial_in     = 1'b0;
    areset        = 1'b1;
    m_axis_tready = 1'b0;
    jit_on        = 1'b0;
    lat_idx       = -1;
    lat_mark      = 0;
    last_mark     = 0;
    clear();
    @(negedge aclk);

    // reset held with the line toggling
    for (int i = 0; i < 4; i++) hold(~serial_in, 1);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_frame_active", frame_active, 0);
    check("rst_eof", eof, 0);
    check("rst_code_err", code_err, 0);
    check("rst_overrun", overrun, 0);
    areset = 1'b0;
    hold(1'b0, 40);

    // clean frame, consumer always ready
    set_ready(1'b1);
    clear();
    q_pre(16);
    q_bits(8'hD5, 8);
    lat_idx = tx_q.size() + 7;
    q_bits(8'hA5, 8);
    q_bits(8'h3C, 8);
    send_q();
    lat_idx = -1;
    settle();
    check("clean_nbeats", rx_q.size(), 2);
    check("clean_beat0", beat(0), 32'hA5);
    check("clean_beat1", beat(1), 32'h3C);
    check("clean_eof_count", eof_cnt, 1);
    check("clean_code_err", err_cnt, 0);
    check("clean_latency", rise_cyc - lat_mark, 3);
    check("clean_eof_delay", eof_cyc - last_mark, EOF_DELAY);
    check("clean_frame_active", frame_active, 0);
    check("clean_tvalid_idle", m_axis_tvalid, 0);

    // same frame with per-half-bit timing jitter
    jit_on = 1'b1;
    clear();
    q_frame();
    send_q();
    jit_on = 1'b0;
    settle();
    check("jit_nbeats", rx_q.size(), 2);
    check("jit_beat0", beat(0), 32'hA5);
    check("jit_beat1", beat(1), 32'h3C);
    check("jit_eof_count", eof_cnt, 1);
    check("jit_code_err", err_cnt, 0);

    // consumer stalled: second byte dropped, overrun sticky
    set_ready(1'b0);
    clear();
    q_frame();
    send_q();
    settle();
    check("stall_tvalid", m_axis_tvalid, 1);
    check("stall_tdata", m_axis_tdata, 32'hA5);
    check("stall_overrun", overrun, 1);
    check("stall_nbeats", rx_q.size(), 0);
    set_ready(1'b1);
    hold(1'b0, 5);
    check("stall_drain_nbeats", rx_q.size(), 1);
    check("stall_drain_beat0", beat(0), 32'hA5);
    check("stall_drain_tvalid", m_axis_tvalid, 0);
    check("stall_overrun_sticky", overrun, 1);
    areset = 1'b1;
    hold(1'b0, 3);
    areset = 1'b0;
    hold(1'b0, 5);
    check("stall_overrun_reset", overrun, 0);

    // early edge inside a data byte
    clear();
    q_pre(16);
    q_bits(8'hD5, 8);
    q_bits(8'hA5, 3);
    send_q();
    check("viol_frame_active_before", frame_active, 1);
    hold(1'b1, int'(SPB / 2));
    hold(1'b0, 3);
    hold(1'b1, 60);
    hold(1'b0, 60);
    check("viol_code_err_cycles", err_cnt, 1);
    check("viol_eof", eof_cnt, 0);
    check("viol_nbeats", rx_q.size(), 0);
    check("viol_frame_active_after", frame_active, 0);
    check("viol_tvalid", m_axis_tvalid, 0);

    // short preamble must not lock
    clear();
    q_bits(8'hA0, 4);
    q_bits(8'hD5, 8);
    q_bits(8'hA5, 8);
    q_bits(8'h3C, 8);
    send_q();
    settle();
    check("short_nbeats", rx_q.size(), 0);
    check("short_eof", eof_cnt, 0);
    check("short_code_err", err_cnt, 0);

    // reset in the middle of a byte with a byte pending in the slot
    set_ready(1'b0);
    clear();
    q_pre(16);
    q_bits(8'hD5, 8);
    q_bits(8'hA5, 8);
    q_bits(8'h3C, 4);
    send_q();
    check("midrst_tvalid_before", m_axis_tvalid, 1);
    check("midrst_tdata_before", m_axis_tdata, 32'hA5);
    check("midrst_frame_active_before", frame_active, 1);
    areset = 1'b1;
    hold(serial_in, 3);
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_tdata", m_axis_tdata, 0);
    check("midrst_frame_active", frame_active, 0);
    areset = 1'b0;
    set_ready(1'b1);
    hold(1'b0, 60);
    clear();
    q_frame();
    send_q();
    settle();
    check("after_nbeats", rx_q.size(), 2);
    check("after_beat0", beat(0), 32'hA5);
    check("after_beat1", beat(1), 32'h3C);
    check("after_eof_count", eof_cnt, 1);
    check("eof_err_exclusive", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
